// File: rtl/fetch_prefetch.sv
// fetch_prefetch
//   Instruction prefetcher. It issues word-aligned fetch requests to memory,
//   keeps up to MAX_OUTSTANDING of them in flight, buffers the in-order
//   responses with their PCs in a FIFO_DEPTH-entry buffer, and presents the
//   buffer head to decode. A redirect flushes the buffer, restarts fetching at
//   the new target and discards the responses still owed for older requests.
//
// Ports
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   next_pc_i           redirect target (low two bits ignored)
//   next_pc_enable_i    redirect strobe
//   req_valid_o/ready_i memory request handshake, req_addr_o = fetch address
//   rsp_valid_i         in-order memory response, no backpressure
//   rsp_data_i          response instruction word
//   instr_valid_o/ready_i decode handshake for the buffer head
//   instr_o, pc_o       head instruction and its PC
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_valid_o/req_addr_o hold until accepted unless a redirect
// withdraws them; ready never influences valid. Responses have no ready and
// are always taken in the cycle they arrive.

module fetch_prefetch #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = 'h8000_0000,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            next_pc_enable_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            rsp_valid_i,
    input  logic [31:0]     rsp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [XLEN-1:0]  pc_mem    [FIFO_DEPTH];
    logic [31:0]      instr_mem [FIFO_DEPTH];

    logic [SUM_W-1:0] in_flight;
    logic [XLEN-1:0]  redirect_pc;
    logic             req_fire;
    logic             rsp_take;
    logic             rsp_keep;
    logic             pop;

    // Requests are only issued while every in-flight response is guaranteed
    // a buffer slot, so a kept response can never meet a full buffer.
    assign in_flight   = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign redirect_pc = next_pc_i & ~XLEN'(3);

    // rstn_i gating keeps both valids low during reset even though the
    // counters already read zero.
    assign req_valid_o   = rstn_i && !next_pc_enable_i
                         && (in_flight < SUM_W'(FIFO_DEPTH))
                         && (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign req_addr_o    = fetch_pc;
    assign instr_valid_o = rstn_i && (fifo_count != '0) && !next_pc_enable_i;
    assign instr_o       = instr_mem[rd_ptr];
    assign pc_o          = pc_mem[rd_ptr];

    assign req_fire = req_valid_o && req_ready_i;
    // A response with nothing outstanding is a memory protocol error; it is
    // ignored so the counters cannot underflow.
    assign rsp_take = rsp_valid_i && (outstanding != '0);
    assign rsp_keep = rsp_take && (drop_cnt == '0) && !next_pc_enable_i;
    assign pop      = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (next_pc_enable_i) begin
            // Every request still owed after this cycle belongs to the old
            // stream, so all of them are dropped when they come back.
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= outstanding - CNT_W'(rsp_take);
            drop_cnt    <= outstanding - CNT_W'(rsp_take);
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (rsp_keep) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                rsp_pc <= rsp_pc + XLEN'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(rsp_keep) - CNT_W'(pop);
        end
    end

    // Storage has no reset; entries are only read once fifo_count covers them.
    // The head is read combinationally before this write lands, so a push into
    // the slot being popped in the same cycle is safe.
    always_ff @(posedge clk_i) begin
        if (rsp_keep) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= rsp_data_i;
        end
    end

    a_rsp_without_request: assert property (
        @(posedge clk_i) disable iff (!rstn_i) rsp_valid_i |-> (outstanding != '0));

    a_no_overcommit: assert property (
        @(posedge clk_i) disable iff (!rstn_i) in_flight <= SUM_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch
//   Drives fetch_prefetch with a cycle-stepped harness. A memory model answers
//   accepted requests in order after a programmable or random latency. The
//   reference model tags each request with a stream epoch: a redirect starts a
//   new epoch and empties the expected buffer, and only responses from the
//   current epoch become expected decode entries.

module tb_fetch_prefetch;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;

    logic            clk_i;
    logic            rstn_i;
    logic [XLEN-1:0] next_pc_i;
    logic            next_pc_enable_i;
    logic            req_valid_o;
    logic            req_ready_i;
    logic [XLEN-1:0] req_addr_o;
    logic            rsp_valid_i;
    logic [31:0]     rsp_data_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;

    fetch_prefetch #(
        .XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .next_pc_i(next_pc_i), .next_pc_enable_i(next_pc_enable_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- model / scoreboard state ----------------
    logic [31:0] pend_addr[$];
    int          pend_cyc[$];
    int          pend_ep[$];
    logic [63:0] exp_q[$];        // {pc, instr} expected at decode, in order
    int          epoch;
    logic [31:0] exp_req_addr;
    int          cyc;
    int          total;
    int          bad;
    bit          lat_rand;
    bit          mem_hold;
    bit          force_rsp;

    // observations of the most recent step
    bit          step_rv, step_fire, step_iv, step_pop, step_rsp;
    logic [31:0] step_addr, step_pc;
    int          step_cyc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // One clock cycle. Called just after a rising edge; drives inputs,
    // checks the combinational outputs, advances the model, then waits.
    task automatic step(input bit redir, input logic [31:0] target,
                        input bit rq_rdy, input bit in_rdy);
        bit          exp_rv, exp_iv, rsp, kept;
        logic [31:0] ra;
        next_pc_enable_i = redir;
        next_pc_i        = target;
        req_ready_i      = rq_rdy;
        instr_ready_i    = in_rdy;
        rsp = 1'b0;
        if (pend_addr.size() > 0 && pend_cyc[0] < cyc) begin
            if (force_rsp) rsp = 1'b1;
            else if (!mem_hold) rsp = lat_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        rsp_valid_i = rsp;
        rsp_data_i  = rsp ? memf(pend_addr[0]) : $urandom();
        #1;
        exp_rv = !redir && (pend_addr.size() + exp_q.size()) < DEPTH && pend_addr.size() < MAXO;
        exp_iv = !redir && exp_q.size() > 0;
        total++;
        if (req_valid_o !== exp_rv) begin
            bad++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, req_valid_o, exp_rv);
        end
        total++;
        if (instr_valid_o !== exp_iv) begin
            bad++;
            $display("FAIL instr_valid cyc=%0d got=%b exp=%b", cyc, instr_valid_o, exp_iv);
        end
        if (exp_rv && req_valid_o) begin
            total++;
            if (req_addr_o !== exp_req_addr) begin
                bad++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, req_addr_o, exp_req_addr);
            end
        end
        if (exp_iv && instr_valid_o) begin
            total++;
            if ({pc_o, instr_o} !== exp_q[0]) begin
                bad++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, pc_o, instr_o, exp_q[0][63:32], exp_q[0][31:0]);
            end
        end
        step_rv   = req_valid_o;
        step_fire = req_valid_o && req_ready_i;
        step_addr = req_addr_o;
        step_iv   = instr_valid_o;
        step_pop  = instr_valid_o && instr_ready_i;
        step_pc   = pc_o;
        step_rsp  = rsp;
        step_cyc  = cyc;
        // model update: pop sees the buffer as it was at cycle start
        if (exp_iv && in_rdy) void'(exp_q.pop_front());
        if (rsp) begin
            kept = !redir && (pend_ep[0] == epoch);
            ra   = pend_addr[0];
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
            void'(pend_ep.pop_front());
            if (kept) exp_q.push_back({ra, memf(ra)});
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_req_addr = {target[31:2], 2'b00};
        end else if (exp_rv && rq_rdy) begin
            pend_addr.push_back(exp_req_addr);
            pend_cyc.push_back(cyc);
            pend_ep.push_back(epoch);
            exp_req_addr = exp_req_addr + 32'd4;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        next_pc_enable_i = 1'b0;
        next_pc_i = '0;
        req_ready_i = 1'b1;
        instr_ready_i = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_data_i = '0;
        #2;
        total++;
        if (req_valid_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_valids got req=%b instr=%b exp 0 0", req_valid_o, instr_valid_o);
        end
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        pend_addr.delete();
        pend_cyc.delete();
        pend_ep.delete();
        exp_q.delete();
        epoch++;
        exp_req_addr = RESET_PC;
        rstn_i = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && !(exp_q.size() == 0 && pend_addr.size() == 0); i++)
            step(1'b0, '0, 1'b0, 1'b1);
        total++;
        if (exp_q.size() != 0 || pend_addr.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout buffered=%0d pending=%0d exp 0 0", exp_q.size(), pend_addr.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (req_valid_o !== 1'b1 || req_addr_o !== RESET_PC) begin
            bad++;
            $display("FAIL reset_first_req got v=%b a=%h exp 1 %h", req_valid_o, req_addr_o, RESET_PC);
        end
        step(1'b0, '0, 1'b0, 1'b1);   // unaccepted: address must hold
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_startup();
        int ff, fi;
        ff = -1;
        fi = -1;
        lat_rand = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (step_fire && ff < 0) ff = step_cyc;
            if (step_iv && fi < 0) fi = step_cyc;
        end
        total++;
        if (ff < 0 || fi - ff != 2) begin
            bad++;
            $display("FAIL startup_latency got=%0d exp=2", fi - ff);
        end
    endtask

    task automatic test_stall();
        int pops;
        lat_rand = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        #1;
        total++;
        if (req_valid_o !== 1'b0 || instr_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_full got req=%b instr=%b exp 0 1", req_valid_o, instr_valid_o);
        end
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (step_pop) pops++;
        end
        total++;
        if (pops != DEPTH) begin
            bad++;
            $display("FAIL stall_entries got=%0d exp=%0d", pops, DEPTH);
        end
    endtask

    task automatic test_redirect();
        bit found;
        drain();
        mem_hold = 1'b1;
        for (int i = 0; i < 10 && pend_addr.size() < 2; i++) step(1'b0, '0, 1'b1, 1'b1);
        total++;
        if (pend_addr.size() != 2) begin
            bad++;
            $display("FAIL redirect_setup got=%0d exp=2", pend_addr.size());
        end
        force_rsp = 1'b1;
        step(1'b1, 32'h8000_0100, 1'b1, 1'b1);
        force_rsp = 1'b0;
        mem_hold  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (step_pop) begin
                found = 1'b1;
                total++;
                if (step_pc !== 32'h8000_0100) begin
                    bad++;
                    $display("FAIL redirect_first_pc got=%h exp=80000100", step_pc);
                end
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL redirect_timeout got no instruction exp pc 80000100");
        end
    endtask

    task automatic test_misaligned();
        step(1'b1, 32'h8000_0106, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        total++;
        if (!step_rv || step_addr !== 32'h8000_0104) begin
            bad++;
            $display("FAIL misaligned got v=%b a=%h exp 1 80000104", step_rv, step_addr);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);   // leave work in flight
        do_reset();                                               // reset mid-operation
        step(1'b1, 32'hffff_fffc, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        total++;
        if (!step_fire || step_addr !== 32'hffff_fffc) begin
            bad++;
            $display("FAIL wrap_first got v=%b a=%h exp 1 fffffffc", step_fire, step_addr);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        total++;
        if (!step_rv || step_addr !== 32'h0000_0000) begin
            bad++;
            $display("FAIL wrap_next got v=%b a=%h exp 1 00000000", step_rv, step_addr);
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h8000_2000, 1'b1, 1'b1);
        step(1'b1, 32'h8000_3008, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        total++;
        if (!step_rv || step_addr !== 32'h8000_3008) begin
            bad++;
            $display("FAIL b2b_addr got v=%b a=%h exp 1 80003008", step_rv, step_addr);
        end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_pop_push();
        int pops;
        drain();
        lat_rand = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() < DEPTH - 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        mem_hold = 1'b1;
        for (int i = 0; i < 10 && pend_addr.size() < 1; i++) step(1'b0, '0, 1'b1, 1'b0);
        total++;
        if (exp_q.size() != DEPTH - 1 || pend_addr.size() != 1) begin
            bad++;
            $display("FAIL poppush_setup got buf=%0d pend=%0d exp 3 1", exp_q.size(), pend_addr.size());
        end
        force_rsp = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);       // push and pop in the same cycle
        force_rsp = 1'b0;
        mem_hold  = 1'b0;
        total++;
        if (!step_pop || !step_rsp) begin
            bad++;
            $display("FAIL poppush_cycle got pop=%b push=%b exp 1 1", step_pop, step_rsp);
        end
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            if (step_pop) pops++;
        end
        total++;
        if (pops != DEPTH - 1) begin
            bad++;
            $display("FAIL poppush_count got=%0d exp=%0d", pops, DEPTH - 1);
        end
    endtask

    task automatic test_random();
        bit          redir;
        logic [31:0] tgt;
        lat_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            redir = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) tgt = 32'hffff_fff0 + $urandom_range(0, 15);
            else tgt = {16'h8000, 16'($urandom())};
            step(redir, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
        end
        lat_rand = 1'b0;
        drain();
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        epoch = 0;
        lat_rand = 1'b0;
        mem_hold = 1'b0;
        force_rsp = 1'b0;
        exp_req_addr = RESET_PC;
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_misaligned();
        test_back_to_back();
        test_pop_push();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
